// File: rtl/instr_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_pkg
//  Description : Shared FSM state type and word/byte geometry helpers for the
//                synchronous instruction memory.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_mem_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_WORD     = DEFAULT_DATA_WIDTH / 8;
    localparam int WORD_SHIFT         = $clog2(BYTES_PER_WORD);

    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int word_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_array
//  Description : Word storage with one write port and one registered,
//                read-first read port. Contents are never reset.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    parameter int IDX_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Both accesses use non-blocking updates, so a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/instruction_memory_sync.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_memory_sync
//  Description : Instruction memory that clears itself to NOP_WORD after reset,
//                then serves 1-cycle-latency fetches and program loads.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_memory_sync
    import instr_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 128,
    parameter int                    ADDR_WIDTH = 9,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  fetch_err,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_err
);

    localparam int                    c_shift = word_shift(DATA_WIDTH);
    localparam int                    c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   c_depth = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [c_idx_w-1:0]    c_last  = c_idx_w'(DEPTH - 1);

    state_t                r_state;
    logic [c_idx_w-1:0]    r_clr_idx;
    logic                  r_use_nop;

    logic [ADDR_WIDTH-1:0] w_fetch_word;
    logic [ADDR_WIDTH-1:0] w_load_word;
    logic                  w_fetch_mis;
    logic                  w_load_mis;
    logic                  w_fetch_ok;
    logic                  w_load_ok;
    logic                  w_we;
    logic [c_idx_w-1:0]    w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_fetch_word = fetch_addr >> c_shift;
    assign w_load_word  = load_addr  >> c_shift;

    generate
        if (c_shift == 0) begin : g_byte_words
            assign w_fetch_mis = 1'b0;
            assign w_load_mis  = 1'b0;
        end else begin : g_align_check
            assign w_fetch_mis = |fetch_addr[c_shift-1:0];
            assign w_load_mis  = |load_addr[c_shift-1:0];
        end
    endgenerate

    // Full-width range compare so high addresses are rejected, never aliased.
    assign w_fetch_ok = !w_fetch_mis && ({1'b0, w_fetch_word} < c_depth);
    assign w_load_ok  = !w_load_mis  && ({1'b0, w_load_word}  < c_depth);

    assign w_we    = (r_state == INIT) ? 1'b1 : (load_en && w_load_ok && !rst);
    assign w_waddr = (r_state == INIT) ? r_clr_idx : w_load_word[c_idx_w-1:0];
    assign w_wdata = (r_state == INIT) ? NOP_WORD : load_data;
    assign w_re    = (r_state == RUN) && fetch_req && w_fetch_ok && !rst;

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (c_idx_w)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .re    (w_re),
        .raddr (w_fetch_word[c_idx_w-1:0]),
        .rdata (w_rdata)
    );

    // The array read register has no reset, so reset/error responses select NOP_WORD.
    assign fetch_instr = r_use_nop ? NOP_WORD : w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_clr_idx   <= '0;
            r_use_nop   <= 1'b1;
            ready       <= 1'b0;
            fetch_valid <= 1'b0;
            fetch_err   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            fetch_valid <= 1'b0;
            load_err    <= 1'b0;
            case (r_state)
                INIT: begin
                    if (r_clr_idx == c_last) begin
                        r_state <= RUN;
                        ready   <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (fetch_req) begin
                        fetch_valid <= 1'b1;
                        fetch_err   <= !w_fetch_ok;
                        r_use_nop   <= !w_fetch_ok;
                    end
                    if (load_en && !w_load_ok) begin
                        load_err <= 1'b1;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_memory_sync
//  Description : Directed bench for instruction_memory_sync, a default 32x128
//                instance (10-bit addresses) and a 64x100 instance.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_memory_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    // 32-bit x 128 instance; the extra address bit lets 0x200 reach the DUT.
    logic        ready0, f0_req, f0_valid, f0_err, l0_en, l0_err;
    logic [9:0]  f0_addr, l0_addr;
    logic [31:0] f0_instr, l0_data;

    // 64-bit x 100 instance.
    logic        ready1, f1_req, f1_valid, f1_err, l1_en, l1_err;
    logic [9:0]  f1_addr, l1_addr;
    logic [63:0] f1_instr, l1_data;

    always #5 clk = ~clk;

    instruction_memory_sync #(
        .DATA_WIDTH (32),
        .DEPTH      (128),
        .ADDR_WIDTH (10),
        .NOP_WORD   (32'h0)
    ) u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready0),
        .fetch_req   (f0_req),
        .fetch_addr  (f0_addr),
        .fetch_valid (f0_valid),
        .fetch_instr (f0_instr),
        .fetch_err   (f0_err),
        .load_en     (l0_en),
        .load_addr   (l0_addr),
        .load_data   (l0_data),
        .load_err    (l0_err)
    );

    instruction_memory_sync #(
        .DATA_WIDTH (64),
        .DEPTH      (100),
        .ADDR_WIDTH (10),
        .NOP_WORD   (64'h0)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready1),
        .fetch_req   (f1_req),
        .fetch_addr  (f1_addr),
        .fetch_valid (f1_valid),
        .fetch_instr (f1_instr),
        .fetch_err   (f1_err),
        .load_en     (l1_en),
        .load_addr   (l1_addr),
        .load_data   (l1_data),
        .load_err    (l1_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Steps through a full clear sequence right after rst falls.
    task automatic run_init(input string tag);
        for (int k = 1; k <= 128; k++) begin
            step();
            check($sformatf("%s_ready0_k%0d", tag, k), {63'd0, ready0}, {63'd0, (k == 128)});
            check($sformatf("%s_ready1_k%0d", tag, k), {63'd0, ready1}, {63'd0, (k >= 100)});
            check($sformatf("%s_fvalid_k%0d", tag, k), {63'd0, f0_valid}, 64'd0);
            check($sformatf("%s_lerr_k%0d", tag, k), {63'd0, l0_err}, 64'd0);
        end
    endtask

    initial begin
        f0_req = 1'b0; f0_addr = '0; l0_en = 1'b0; l0_addr = '0; l0_data = '0;
        f1_req = 1'b0; f1_addr = '0; l1_en = 1'b0; l1_addr = '0; l1_data = '0;

        // Reset state
        rst = 1'b1;
        step();
        step();
        check("rst_ready",  {63'd0, ready0},   64'd0);
        check("rst_valid",  {63'd0, f0_valid}, 64'd0);
        check("rst_ferr",   {63'd0, f0_err},   64'd0);
        check("rst_lerr",   {63'd0, l0_err},   64'd0);
        check("rst_instr",  {32'd0, f0_instr}, 64'd0);

        // Clear sequence with fetches and a load held active, which must be ignored
        rst = 1'b0;
        f0_req = 1'b1; f0_addr = 10'h040;
        l0_en = 1'b1; l0_addr = 10'h040; l0_data = 32'hDEADBEEF;
        run_init("init");
        f0_req = 1'b0; l0_en = 1'b0;

        check("init_ignored_fetch", {63'd0, f0_valid}, 64'd0);
        f0_req = 1'b1; f0_addr = 10'h040;
        step();
        check("idle_valid", {63'd0, f0_valid}, 64'd1);
        check("idle_instr", {32'd0, f0_instr}, 64'd0);
        check("idle_err",   {63'd0, f0_err},   64'd0);
        f0_req = 1'b0;

        // Load then fetch
        l0_en = 1'b1; l0_addr = 10'h010; l0_data = 32'h8B020020;
        step();
        check("load_ok_lerr", {63'd0, l0_err}, 64'd0);
        l0_en = 1'b0;
        f0_req = 1'b1; f0_addr = 10'h010;
        step();
        check("ld_fetch_valid", {63'd0, f0_valid}, 64'd1);
        check("ld_fetch_instr", {32'd0, f0_instr}, 64'h8B020020);
        check("ld_fetch_err",   {63'd0, f0_err},   64'd0);
        f0_req = 1'b0;
        step();
        check("hold_valid", {63'd0, f0_valid}, 64'd0);
        check("hold_instr", {32'd0, f0_instr}, 64'h8B020020);

        // Misaligned and out-of-range fetches
        f0_req = 1'b1; f0_addr = 10'h012;
        step();
        check("mis_valid", {63'd0, f0_valid}, 64'd1);
        check("mis_err",   {63'd0, f0_err},   64'd1);
        check("mis_instr", {32'd0, f0_instr}, 64'd0);
        f0_addr = 10'h200;
        step();
        check("oor_valid", {63'd0, f0_valid}, 64'd1);
        check("oor_err",   {63'd0, f0_err},   64'd1);
        check("oor_instr", {32'd0, f0_instr}, 64'd0);
        f0_req = 1'b0;

        // Rejected loads: out of range, then misaligned
        l0_en = 1'b1; l0_addr = 10'h200; l0_data = 32'hFFFFFFFF;
        step();
        check("oor_load_err", {63'd0, l0_err}, 64'd1);
        l0_addr = 10'h012; l0_data = 32'h11111111;
        step();
        check("mis_load_err", {63'd0, l0_err}, 64'd1);
        l0_en = 1'b0;
        step();
        check("lerr_pulse_end", {63'd0, l0_err}, 64'd0);
        f0_req = 1'b1; f0_addr = 10'h000;
        step();
        check("no_alias_instr", {32'd0, f0_instr}, 64'd0);
        check("no_alias_err",   {63'd0, f0_err},   64'd0);
        f0_addr = 10'h010;
        step();
        check("mis_load_unchanged", {32'd0, f0_instr}, 64'h8B020020);
        f0_req = 1'b0;

        // Same-cycle load and fetch: read-first, then back-to-back fetches
        l0_en = 1'b1; l0_addr = 10'h020; l0_data = 32'hAAAA5555;
        f0_req = 1'b1; f0_addr = 10'h020;
        step();
        check("rf_old_valid", {63'd0, f0_valid}, 64'd1);
        check("rf_old_instr", {32'd0, f0_instr}, 64'd0);
        l0_en = 1'b0;
        step();
        check("rf_new_valid", {63'd0, f0_valid}, 64'd1);
        check("rf_new_instr", {32'd0, f0_instr}, 64'hAAAA5555);
        f0_addr = 10'h010;
        step();
        check("b2b_valid", {63'd0, f0_valid}, 64'd1);
        check("b2b_instr", {32'd0, f0_instr}, 64'h8B020020);
        f0_req = 1'b0;

        // 64x100 instance: boundary, load, back-to-back
        l1_en = 1'b1; l1_addr = 10'h318; l1_data = 64'h0123456789ABCDEF;
        step();
        check("w64_load_lerr", {63'd0, l1_err}, 64'd0);
        l1_addr = 10'h320;
        step();
        check("w64_oor_load_err", {63'd0, l1_err}, 64'd1);
        l1_en = 1'b0;
        f1_req = 1'b1; f1_addr = 10'h318;
        step();
        check("w64_last_valid", {63'd0, f1_valid}, 64'd1);
        check("w64_last_err",   {63'd0, f1_err},   64'd0);
        check("w64_last_instr", f1_instr,          64'h0123456789ABCDEF);
        f1_addr = 10'h320;
        step();
        check("w64_oor_valid", {63'd0, f1_valid}, 64'd1);
        check("w64_oor_err",   {63'd0, f1_err},   64'd1);
        check("w64_oor_instr", f1_instr,          64'd0);
        f1_addr = 10'h000;
        step();
        check("w64_b2b_valid", {63'd0, f1_valid}, 64'd1);
        check("w64_b2b_err",   {63'd0, f1_err},   64'd0);
        check("w64_b2b_instr", f1_instr,          64'd0);
        f1_addr = 10'h00C;
        step();
        check("w64_mis_err", {63'd0, f1_err}, 64'd1);
        f1_req = 1'b0;
        step();
        check("w64_idle_valid", {63'd0, f1_valid}, 64'd0);

        // Reset arriving together with a fetch request
        f0_req = 1'b1; f0_addr = 10'h010;
        rst = 1'b1;
        step();
        check("rstf_valid", {63'd0, f0_valid}, 64'd0);
        check("rstf_ready", {63'd0, ready0},   64'd0);
        check("rstf_instr", {32'd0, f0_instr}, 64'd0);
        f0_req = 1'b0;
        rst = 1'b0;

        // Reset again at clear index 60 with a fetch pending
        for (int k = 0; k < 60; k++) begin
            step();
        end
        check("mid_init_ready", {63'd0, ready0}, 64'd0);
        f0_req = 1'b1; rst = 1'b1;
        step();
        check("mid_rst_valid", {63'd0, f0_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, ready0},   64'd0);
        f0_req = 1'b0; rst = 1'b0;
        run_init("reinit");

        // Contents were cleared by the restarted sequence
        f0_req = 1'b1; f0_addr = 10'h010;
        step();
        check("cleared_valid", {63'd0, f0_valid}, 64'd1);
        check("cleared_instr", {32'd0, f0_instr}, 64'd0);
        f0_addr = 10'h020;
        step();
        check("cleared_instr2", {32'd0, f0_instr}, 64'd0);
        f0_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
